// File: rtl/inst_decode_pkg.sv
// Shared MIPS decode constants: format classes, opcodes and instruction field positions.
package inst_decode_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_J = 2'b10
  } fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNC_HI  = 5;
  localparam int unsigned FUNC_LO  = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned TGT_HI   = 25;
  localparam int unsigned TGT_LO   = 0;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic imm_is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational split of one {pc, inst} pair into MIPS fields, format, immediate and jump target.
module inst_field_decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic [5:0]      o_op,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_shamt,
  output logic [5:0]      o_func,
  output logic [XLEN-1:0] o_imm_ext,
  output logic [XLEN-1:0] o_jtarget,
  output logic [1:0]      o_fmt
);
  import inst_decode_pkg::*;

  localparam logic [XLEN-1:0] PC_HI_MASK = {{(XLEN-28){1'b1}}, 28'h0};

  logic [XLEN-1:0] w_pc4;
  logic [15:0]     w_imm;
  fmt_e            w_fmt;

  assign o_op    = i_inst[OP_HI:OP_LO];
  assign o_rs    = i_inst[RS_HI:RS_LO];
  assign o_rt    = i_inst[RT_HI:RT_LO];
  assign o_rd    = i_inst[RD_HI:RD_LO];
  assign o_shamt = i_inst[SHAMT_HI:SHAMT_LO];
  assign o_func  = i_inst[FUNC_HI:FUNC_LO];
  assign w_imm   = i_inst[IMM_HI:IMM_LO];

  assign o_imm_ext = imm_is_zext(o_op) ? {{(XLEN-16){1'b0}}, w_imm}
                                       : {{(XLEN-16){w_imm[15]}}, w_imm};

  // Upper bits come from pc+4 (carry included); low 28 bits are the shifted target.
  assign w_pc4     = i_pc + XLEN'(4);
  assign o_jtarget = (w_pc4 & PC_HI_MASK) |
                     {{(XLEN-28){1'b0}}, i_inst[TGT_HI:TGT_LO], 2'b00};

  always_comb begin
    w_fmt = FMT_I;
    if (o_op == OP_RTYPE)                      w_fmt = FMT_R;
    else if ((o_op == OP_J) || (o_op == OP_JAL)) w_fmt = FMT_J;
  end

  assign o_fmt = w_fmt;

endmodule

// File: rtl/inst_decode_queue.sv
// In-order queue of decoded instructions between fetch and register-read, with synchronous flush.
module inst_decode_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [5:0]       out_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_func,
  output logic [XLEN-1:0]  out_imm_ext,
  output logic [XLEN-1:0]  out_jtarget,
  output logic [1:0]       out_fmt,
  output logic [CNT_W-1:0] count
);
  import inst_decode_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FLD_W = 6 + 5 + 5 + 5 + 5 + 6 + 2;

  logic [XLEN-1:0]  r_pc_mem  [DEPTH];
  logic [XLEN-1:0]  r_imm_mem [DEPTH];
  logic [XLEN-1:0]  r_jt_mem  [DEPTH];
  logic [FLD_W-1:0] r_fld_mem [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [5:0]       w_op;
  logic [4:0]       w_rs, w_rt, w_rd, w_shamt;
  logic [5:0]       w_func;
  logic [1:0]       w_fmt;
  logic [XLEN-1:0]  w_imm_ext;
  logic [XLEN-1:0]  w_jtarget;
  logic [FLD_W-1:0] w_fld_out;

  inst_field_decode #(.XLEN(XLEN)) u_dec (
    .i_pc      (in_pc),
    .i_inst    (in_inst),
    .o_op      (w_op),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_rd      (w_rd),
    .o_shamt   (w_shamt),
    .o_func    (w_func),
    .o_imm_ext (w_imm_ext),
    .o_jtarget (w_jtarget),
    .o_fmt     (w_fmt)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]  <= in_pc;
      r_imm_mem[r_tail] <= w_imm_ext;
      r_jt_mem[r_tail]  <= w_jtarget;
      r_fld_mem[r_tail] <= {w_op, w_rs, w_rt, w_rd, w_shamt, w_func, w_fmt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= next_ptr(r_tail);
      if (w_pop)  r_head <= next_ptr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale storage is never visible: every data output is forced to zero while empty.
  assign w_fld_out   = out_valid ? r_fld_mem[r_head] : '0;
  assign out_pc      = out_valid ? r_pc_mem[r_head]  : '0;
  assign out_imm_ext = out_valid ? r_imm_mem[r_head] : '0;
  assign out_jtarget = out_valid ? r_jt_mem[r_head]  : '0;
  assign {out_op, out_rs, out_rt, out_rd, out_shamt, out_func, out_fmt} = w_fld_out;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Randomized self-checking bench for inst_decode_queue against a queue-based reference model.
module tb_inst_decode_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc = '0;
  logic [31:0]      in_inst = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [5:0]       out_op;
  logic [4:0]       out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]       out_func;
  logic [XLEN-1:0]  out_imm_ext;
  logic [XLEN-1:0]  out_jtarget;
  logic [1:0]       out_fmt;
  logic [CNT_W-1:0] count;

  inst_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_op      (out_op),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_func    (out_func),
    .out_imm_ext (out_imm_ext),
    .out_jtarget (out_jtarget),
    .out_fmt     (out_fmt),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   last_push;

  logic [133:0] w_obs;
  assign w_obs = {in_ready, out_valid, out_pc, out_op, out_rs, out_rt, out_rd,
                  out_shamt, out_func, out_imm_ext, out_jtarget, out_fmt, count};

  // Expected observable vector computed straight from the field/format/extension rules.
  function automatic logic [133:0] exp_obs();
    logic [31:0] pc, inst, imm, jt;
    logic [5:0]  op;
    logic [1:0]  fmt;
    if (mq.size() == 0) return {1'b1, 133'b0};
    pc   = mq[0].pc;
    inst = mq[0].inst;
    op   = inst[31:26];
    if (op == 6'h00)                     fmt = 2'b00;
    else if (op == 6'h02 || op == 6'h03) fmt = 2'b10;
    else                                 fmt = 2'b01;
    if (op >= 6'h0C && op <= 6'h0F) imm = {16'h0000, inst[15:0]};
    else                            imm = {{16{inst[15]}}, inst[15:0]};
    jt = ((pc + 32'd4) & 32'hF000_0000) | {4'h0, inst[25:0], 2'b00};
    return {(mq.size() < DEPTH), 1'b1, pc, inst, imm, jt, fmt, 2'(mq.size())};
  endfunction

  task automatic step();
    bit mpush, mpop;
    @(posedge clk);
    mpush = in_valid && (mq.size() < DEPTH);
    mpop  = (mq.size() != 0) && out_ready;
    last_push = mpush && !reset && !flush;
    if (reset || flush) mq.delete();
    else begin
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back('{in_pc, in_inst});
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    logic [5:0]  ops [8];
    ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[31:26] = ops[$urandom_range(0, 7)];
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    nvec++;
    if (w_obs !== exp_obs()) begin
      nerr++; $display("FAIL reset obs=%h exp=%h", w_obs, exp_obs());
    end
  endtask

  task automatic test_rtype();
    in_valid = 1'b1; in_pc = 32'h0040_0000; in_inst = 32'h012A_4020;
    step();
    in_valid = 1'b0;
    nvec++;
    if (w_obs !== exp_obs()) begin
      nerr++; $display("FAIL rtype obs=%h exp=%h", w_obs, exp_obs());
    end
    nvec++;
    if ({out_valid, out_fmt, out_rs, out_rt, out_rd, out_func, count} !==
        {1'b1, 2'b00, 5'd9, 5'd10, 5'd8, 6'h20, 2'd1}) begin
      nerr++;
      $display("FAIL rtype_fields got v=%b fmt=%b rs=%0d rt=%0d rd=%0d func=%h cnt=%0d want 1 00 9 10 8 20 1",
               out_valid, out_fmt, out_rs, out_rt, out_rd, out_func, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    nvec++;
    if (w_obs !== exp_obs()) begin
      nerr++; $display("FAIL rtype_pop obs=%h exp=%h", w_obs, exp_obs());
    end
  endtask

  task automatic test_imm();
    in_valid = 1'b1; in_pc = 32'h0040_0010; in_inst = 32'h2108_FFFF;
    step();
    in_valid = 1'b0;
    nvec++;
    if ({out_imm_ext, out_fmt} !== {32'hFFFF_FFFF, 2'b01} || w_obs !== exp_obs()) begin
      nerr++; $display("FAIL imm_addi got imm=%h fmt=%b want ffffffff 01", out_imm_ext, out_fmt);
    end
    in_valid = 1'b1; in_pc = 32'h0040_0014; in_inst = 32'h3508_FFFF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    nvec++;
    if ({out_imm_ext, out_fmt, count} !== {32'h0000_FFFF, 2'b01, 2'd1} || w_obs !== exp_obs()) begin
      nerr++; $display("FAIL imm_ori got imm=%h fmt=%b cnt=%0d want 0000ffff 01 1", out_imm_ext, out_fmt, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_jump();
    in_valid = 1'b1; in_pc = 32'h1FFF_FFFC; in_inst = 32'h0800_0010;
    step();
    in_valid = 1'b0;
    nvec++;
    if ({out_jtarget, out_fmt} !== {32'h2000_0040, 2'b10} || w_obs !== exp_obs()) begin
      nerr++; $display("FAIL jump got jt=%h fmt=%b want 20000040 10", out_jtarget, out_fmt);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int cyc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h0000_1000 + 32'(k * 4); in_inst = rand_inst();
      step();
      if (last_push) k++;
    end
    nvec++;
    if ({in_ready, count, 32'(k)} !== {1'b0, 2'd2, 32'd2} || w_obs !== exp_obs()) begin
      nerr++; $display("FAIL full_hold got in_ready=%b cnt=%0d accepted=%0d want 0 2 2", in_ready, count, k);
    end
    out_ready = 1'b1;
    while ((k < 3 || mq.size() != 0) && cyc < 10) begin
      in_valid = (k < 3);
      in_pc = 32'h0000_1000 + 32'(k * 4);
      step();
      if (last_push) begin k++; in_inst = rand_inst(); end
      cyc++;
      nvec++;
      if (w_obs !== exp_obs()) begin
        nerr++; $display("FAIL drain obs=%h exp=%h", w_obs, exp_obs());
      end
    end
    nvec++;
    if (k != 3 || mq.size() != 0) begin
      nerr++; $display("FAIL drain_timeout accepted=%0d left=%0d want 3 0", k, mq.size());
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = $urandom; in_inst = rand_inst();
      step();
      nvec++;
      if (w_obs !== exp_obs() || (i > 0 && count !== 2'd1)) begin
        nerr++; $display("FAIL stream%0d obs=%h exp=%h", i, w_obs, exp_obs());
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = 32'h0000_2000; in_inst = rand_inst(); step();
    in_pc = 32'h0000_2004; in_inst = rand_inst(); out_ready = 1'b1; step();
    out_ready = 1'b0; in_inst = rand_inst(); flush = 1'b1;
    step();
    flush = 1'b0;
    nvec++;
    if ({out_valid, count} !== 3'b0_00 || w_obs !== exp_obs()) begin
      nerr++; $display("FAIL flush_push got v=%b cnt=%0d want 0 0", out_valid, count);
    end
    in_pc = 32'h0000_3000; step();
    in_pc = 32'h0000_3004; step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    nvec++;
    if ({out_valid, count} !== 3'b0_00 || w_obs !== exp_obs()) begin
      nerr++; $display("FAIL flush_full got v=%b cnt=%0d want 0 0", out_valid, count);
    end
    in_pc = 32'h0000_4000; step();
    in_pc = 32'h0000_4004; step();
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    nvec++;
    if (w_obs !== exp_obs()) begin
      nerr++; $display("FAIL reset_flush obs=%h exp=%h", w_obs, exp_obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      in_pc     = $urandom;
      in_inst   = rand_inst();
      step();
      nvec++;
      if (w_obs !== exp_obs()) begin
        nerr++; $display("FAIL random%0d obs=%h exp=%h", i, w_obs, exp_obs());
      end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_jump();
    test_back_to_back();
    test_stream();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
